// File: rtl/md_pkg.sv
// Shared decode constants and FSM encoding for the iterative multiply/divide unit.
package md_pkg;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic is_md_funct(input logic [5:0] f);
    return f inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
                     FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO};
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Unsigned one-bit-per-step datapath: shift-add multiply and restoring divide
// sharing one remainder/accumulator-high register and one low/quotient register.
module md_iter_core
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               div_mode,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_low;
  logic [WIDTH-1:0] r_opd;
  logic             r_div;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  // The partial remainder is always below the divisor, so its top bit only
  // exists transiently in w_shift and never needs to be stored.
  always_comb begin
    w_sum   = {1'b0, r_rem} + (r_low[0] ? {1'b0, r_opd} : '0);
    w_shift = {r_rem, r_low[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_opd});
    w_diff  = w_shift[WIDTH-1:0] - r_opd;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= '0;
      r_low <= '0;
      r_opd <= '0;
      r_div <= 1'b0;
    end else if (load) begin
      r_rem <= '0;
      r_low <= a_mag;
      r_opd <= b_mag;
      r_div <= div_mode;
    end else if (step) begin
      if (r_div) begin
        r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
        r_low <= {r_low[WIDTH-2:0], w_ge};
      end else begin
        r_rem <= w_sum[WIDTH:1];
        r_low <= {w_sum[0], r_low[WIDTH-1:1]};
      end
    end
  end

  assign product   = {r_rem, r_low};
  assign quotient  = r_low;
  assign remainder = r_rem;

endmodule

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: funct decode, IDLE/RUN/FIX sequencing, sign
// fixup around the magnitude core, and the architectural HI/LO registers.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic               r_div;
  logic               r_a_neg;
  logic               r_b_neg;
  logic               r_b_zero;
  logic [WIDTH-1:0]   r_a_raw;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_is_mult;
  logic               w_is_div;
  logic               w_is_signed;
  logic               w_accept;
  logic               w_start;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_last;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_hi_new;
  logic [WIDTH-1:0]   w_lo_new;

  assign w_is_mult   = (funct == FN_MULT) || (funct == FN_MULTU);
  assign w_is_div    = (funct == FN_DIV)  || (funct == FN_DIVU);
  assign w_is_signed = SIGNED_EN && ((funct == FN_MULT) || (funct == FN_DIV));
  assign w_accept    = valid && !flush && (r_state == S_IDLE);
  assign w_start     = w_accept && (w_is_mult || w_is_div);
  assign w_a_neg     = w_is_signed && a[WIDTH-1];
  assign w_b_neg     = w_is_signed && b[WIDTH-1];
  assign w_a_mag     = w_a_neg ? -a : a;
  assign w_b_mag     = w_b_neg ? -b : b;
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (w_start),
    .step      (r_state == S_RUN),
    .div_mode  (w_is_div),
    .a_mag     (w_a_mag),
    .b_mag     (w_b_mag),
    .product   (w_prod),
    .quotient  (w_quot),
    .remainder (w_rem)
  );

  // Divide-by-zero bypasses sign fixup: LO is all ones, HI the raw dividend.
  always_comb begin
    w_prod_fix = (r_a_neg ^ r_b_neg) ? -w_prod : w_prod;
    w_hi_new   = w_prod_fix[2*WIDTH-1:WIDTH];
    w_lo_new   = w_prod_fix[WIDTH-1:0];
    if (r_div) begin
      if (r_b_zero) begin
        w_hi_new = r_a_raw;
        w_lo_new = '1;
      end else begin
        w_hi_new = r_a_neg ? -w_rem : w_rem;
        w_lo_new = (r_a_neg ^ r_b_neg) ? -w_quot : w_quot;
      end
    end
  end

  // NOTE: w_next takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_RUN;
      S_RUN:   if (flush) w_next = S_IDLE;
               else if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_div    <= 1'b0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_b_zero <= 1'b0;
      r_a_raw  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && funct == FN_MTHI) r_hi <= a;
          if (w_accept && funct == FN_MTLO) r_lo <= a;
          if (w_start) begin
            r_cnt    <= '0;
            r_div    <= w_is_div;
            r_a_neg  <= w_a_neg;
            r_b_neg  <= w_b_neg;
            r_b_zero <= (b == '0);
            r_a_raw  <= a;
          end
        end
        S_RUN: if (!flush) r_cnt <= r_cnt + 1'b1;
        S_FIX: begin
          if (!flush) begin
            r_hi   <= w_hi_new;
            r_lo   <= w_lo_new;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (funct == FN_MFHI)      rdata = r_hi;
    else if (funct == FN_MFLO) rdata = r_lo;
  end

  assign busy  = (r_state != S_IDLE);
  assign stall = valid && busy && is_md_funct(funct);
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: directed ops push expected HI/LO, a negedge
// monitor pops and compares on every done pulse.
module tb_md_unit;
  import md_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid, flush;
  logic [5:0]   funct;
  logic [W-1:0] a, b;
  logic [W-1:0] rdata, hi, lo;
  logic         busy, stall, done;

  logic         valid2, flush2;
  logic [5:0]   funct2;
  logic [W-1:0] a2, b2;
  logic [W-1:0] rdata2, hi2, lo2;
  logic         busy2, stall2, done2;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .valid(valid), .funct(funct), .a(a), .b(b),
    .flush(flush), .rdata(rdata), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

  md_unit #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .valid(valid2), .funct(funct2), .a(a2), .b(b2),
    .flush(flush2), .rdata(rdata2), .busy(busy2), .stall(stall2), .done(done2),
    .hi(hi2), .lo(lo2)
  );

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("done with empty scoreboard", {63'd0, done}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, " hi"}, hi, e.hi);
        check({e.name, " lo"}, lo, e.lo);
      end
    end
  end

  task automatic run_op(input string name, input logic [5:0] f, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n;
    @(posedge clk); #1;
    sb.push_back('{name, ehi, elo});
    valid = 1'b1; funct = f; a = x; b = y;
    @(posedge clk); #1;
    valid = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check({name, " busy cycles"}, n, 33);
    check({name, " done pulse"}, done, 1);
  endtask

  task automatic run_u(input string name, input logic [5:0] f, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n;
    @(posedge clk); #1;
    valid2 = 1'b1; funct2 = f; a2 = x; b2 = y;
    @(posedge clk); #1;
    valid2 = 1'b0;
    n = 0;
    while (n < 100 && done2 !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check({name, " done seen"}, done2, 1);
    check({name, " hi"}, hi2, ehi);
    check({name, " lo"}, lo2, elo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, s, d;
    rst = 1'b1; valid = 1'b0; flush = 1'b0; funct = FN_MFHI; a = '0; b = '0;
    valid2 = 1'b0; flush2 = 1'b0; funct2 = 6'd0; a2 = '0; b2 = '0;
    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset rdata", rdata, 0);
    @(negedge clk); rst = 1'b0;

    run_op("mult -3*7",     FN_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu max*max", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("div -7/2",      FN_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu 7/0",      FN_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF);
    run_op("div min/-1",    FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("div -7/0",      FN_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div 7/-2",      FN_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);

    // mtlo presented in the done cycle
    valid = 1'b1; funct = FN_MTLO; a = 32'h55;
    @(posedge clk); #1;
    valid = 1'b0;
    check("b2b mtlo lo", lo, 32'h55);
    check("b2b mtlo hi", hi, 32'h1);
    check("b2b mtlo busy", busy, 0);

    valid = 1'b1; funct = FN_MTHI; a = 32'h1234;
    @(posedge clk); #1;
    valid = 1'b0;
    check("mthi hi", hi, 32'h1234);
    check("mthi no busy", busy, 0);
    check("mthi no done", done, 0);
    funct = FN_MFLO; #1 check("mflo rdata", rdata, 32'h55);
    funct = FN_MFHI; #1 check("mfhi rdata", rdata, 32'h1234);
    funct = 6'h20;   #1 check("non-md rdata", rdata, 0);

    // stall while busy; mthi during busy must be ignored
    @(posedge clk); #1;
    sb.push_back('{"mult 5*6", 32'h0, 32'h1E});
    valid = 1'b1; funct = FN_MULT; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    funct = FN_MTHI; a = 32'hDEAD;
    n = 0; s = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!busy) break;
      if (stall) s++;
      n++;
      if (n == 15) funct = FN_MFHI;
      if (n == 20) check("hi held during busy", hi, 32'h1234);
    end
    check("stall mult busy cycles", n, 33);
    check("stall cycles", s, 33);
    check("stall clear in done cycle", stall, 0);
    check("mfhi after mult", rdata, 32'h0);
    valid = 1'b0;

    // flush divu in its 10th RUN cycle
    @(posedge clk); #1;
    valid = 1'b1; funct = FN_MTHI; a = 32'h77;
    @(posedge clk); #1;
    funct = FN_DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy cleared", busy, 0);
    d = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) d++;
    end
    check("flush no done", d, 0);
    check("flush hi kept", hi, 32'h77);
    check("flush lo kept", lo, 32'h1E);

    // asynchronous reset in the middle of a mult
    @(posedge clk); #1;
    valid = 1'b1; funct = FN_MULT; a = 32'd3; b = 32'd7;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", busy, 0);
    check("async rst hi", hi, 0);
    check("async rst lo", lo, 0);
    check("async rst done", done, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post rst idle", busy, 0);

    run_u("unsigned-only mult max*max", FN_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_u("unsigned-only div",          FN_DIV,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC);

    repeat (5) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with its own funct decoder. It is the successor to the combinational ALU-control decode.
- Decodes the MIPS R-type HI/LO functs (mult, multu, div, divu, mfhi, mflo, mthi, mtlo).
- Runs mult/div iteratively, one bit per cycle, and owns the HI/LO registers.
- Sits beside the main ALU in the EX stage. The CPU stalls on `stall`.

Parameters:
- WIDTH, default 32: operand, HI and LO width.
- SIGNED_EN, default 1: 1 = signed mult/div supported; 0 = mult/div execute as multu/divu.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid  in  1  EX holds an R-type instruction whose funct is presented.
- funct  in  6  instruction funct field.
- a  in  WIDTH  rs value (dividend, multiplicand, or mthi/mtlo data).
- b  in  WIDTH  rt value (divisor, multiplier).
- flush  in  1  synchronous abort of the in-flight op.
- rdata  out  WIDTH  HI for mfhi, LO for mflo, else 0. Combinational.
- busy  out  1  iterative op in flight.
- stall  out  1  valid & busy & funct is any md funct.
- done  out  1  one-cycle pulse: HI/LO just written by mult/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; hi, lo, counter and all datapath registers =0.
  - busy=done=stall=0 immediately.
- Decode:
  - Funct codes: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo.
  - Any other funct: no effect, rdata=0.
- Acceptance:
  - An op is accepted at a rising edge with valid=1, state=IDLE, flush=0.
  - While busy, valid is ignored, so stall=1 for md functs.
- mthi/mtlo: accepted edge writes a to hi/lo. Single cycle, no busy, no done.
- mfhi/mflo: rdata is combinational from the current hi/lo. While busy, stall is asserted and rdata is don't-care.
- FSM states: IDLE, RUN, FIX.
  - IDLE->RUN on accepted mult/multu/div/divu.
    - Latch |a| and |b| (magnitudes only when signed op and SIGNED_EN=1).
    - Latch sign flags; counter=0.
  - RUN: one iteration per edge.
    - Mult: shift-add over a 2*WIDTH accumulator.
    - Div: restoring, remainder WIDTH+1 bits.
    - Counter width clog2(WIDTH)+1.
    - After WIDTH iterations -> FIX.
  - FIX: one edge.
    - Apply sign fixup and write hi/lo; -> IDLE.
    - done=1 during the following cycle.
- Latency: accept edge E0. busy=1 in cycles after E0 through E(WIDTH+1). hi/lo written at E(WIDTH+1). busy=0 and done=1 in the cycle after E(WIDTH+1), so total busy = WIDTH+1 cycles.
- Sign rules (signed ops only):
  - Product is negated if the operand signs differ; {hi,lo}=2*WIDTH product.
  - Quotient (lo) is negated if signs differ.
  - Remainder (hi) takes the dividend's sign.
- Division by zero, all variants: lo={WIDTH{1}}, hi=a as latched raw. No sign fixup.
- Signed overflow, MIN/-1: lo=MIN, hi=0. This falls out of the magnitude arithmetic.
- flush:
  - In RUN or FIX: next edge ->IDLE; hi/lo unchanged; no done.
  - flush with valid in IDLE: op not accepted (flush wins).
- A new op may be accepted in the done cycle. HI/LO of a back-to-back mtlo after done write normally.

Decomposition:
- Shared package md_pkg:
  - Funct localparams (FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO).
  - State encoding (S_IDLE, S_RUN, S_FIX).
- Sub-module md_iter_core:
  - Magnitude shift-add / restoring-divide datapath with a step input and WIDTH parameter.
  - Outputs raw product, quotient and remainder.
- md_unit holds decode, FSM, counter, sign fixup and HI/LO.

Test Plan:
- mult a=0xFFFFFFFD (-3), b=7 -> busy for 33 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Same op with SIGNED_EN=0 using mult gives an identical result.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
- div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- mthi a=0x1234, then mflo -> rdata=lo. Issue mult, then mfhi while busy -> stall=1 until the done cycle; mthi during busy leaves hi unchanged.
- flush on the 10th RUN cycle of divu -> busy=0 next cycle, no done, hi/lo keep prior values. rst pulse mid-mult -> hi=lo=0 and busy=0 without a clock edge.
